regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Write-port scheduler and scoreboard for the 32-entry integer register file. Shares the register file's single write port among three writeback requesters (EXU, LSU, MDU) using round-robin arbitration. Tracks in-flight destination registers so the issue stage stalls on RAW/WAW hazards. Sits between the execution units and the register file, beside the decode/issue stage.

## Interface
- DATA_WIDTH, 64, register data width
- NREG, 32, register count; the scoreboard is NREG bits wide, and x0 is never tracked
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- exu_valid / lsu_valid / mdu_valid  in  1 each  requester has a write pending
- exu_rd / lsu_rd / mdu_rd  in  5 each  destination register
- exu_data / lsu_data / mdu_data  in  DATA_WIDTH each  write data
- exu_ready / lsu_ready / mdu_ready  out  1 each  write accepted this cycle
- rf_wen  out  1  to register file write enable
- rf_rd  out  5  to register file write address
- rf_wdata  out  DATA_WIDTH  to register file write data
- iss_valid  in  1  decode presents an instruction
- iss_wen  in  1  instruction writes rd
- iss_rd, iss_rs1, iss_rs2  in  5 each  instruction register fields
- iss_use_rs1, iss_use_rs2  in  1 each  operand actually read
- iss_stall  out  1  instruction must not issue this cycle
- busy  out  NREG  scoreboard state, exposed for debug

## Operation
- Arbiter state: 2-bit round-robin pointer ptr (0=EXU, 1=LSU, 2=MDU). Priority order is ptr, ptr+1, ptr+2 (mod 3). Encoding 3 is illegal and is treated as 0.
- Grant is combinational. The highest-priority valid requester gets ready=1; at most one ready is high per cycle.
- A transfer happens when valid && ready. The requester holds rd and data stable until it sees ready.
- On a transfer, ptr moves to the slot after the granted requester. If there is no transfer, ptr holds.
- rf_wen = transfer && rd!=0. rf_rd and rf_wdata are muxed from the granted requester, and are 0 when there is no grant.
- A write to rd=0 is still a transfer: ready=1 and ptr advances, but rf_wen=0.
- Scoreboard set: on iss_valid && !iss_stall && iss_wen && iss_rd!=0, set busy[iss_rd].
- Scoreboard clear: on a transfer with rd!=0, clear busy[rd].
- If set and clear hit the same index in the same cycle, set wins.
- Hazard terms, with wb_hit(r) = rf_wen && rf_rd==r:
  - RAW on an operand: iss_use_rsN && rsN!=0 && busy[rsN] && !wb_hit(rsN). The register file forwards same-cycle write data, so a register being written this cycle is not a hazard.
  - WAW: iss_wen && iss_rd!=0 && busy[iss_rd] && !wb_hit(iss_rd).
  - iss_stall = iss_valid && (RAW on rs1 || RAW on rs2 || WAW).
- Every writeback with rd!=0 must target a busy register. Writing a non-busy rd is a protocol error; it is flagged by an assertion and leaves busy unchanged.

## Timing
- Reset values: busy=0, ptr=0. All outputs follow combinationally: readies 0 unless valid, rf_wen=0 with no valids, iss_stall=0 with busy=0.
- Reset is asynchronous: busy and ptr clear immediately on rst, regardless of clk.
- A write accepted in cycle N appears in the register file after edge N. The busy bit clears on the same edge.
- Throughput: one writeback per cycle. With all three requesters continuously valid, each is granted once every 3 cycles.
- An issue that stalls in cycle N may issue in cycle N if the blocking register is written back in N (forwarding). Otherwise it issues no earlier than N+1.
- No combinational path from iss_* to any *_ready.

## Test plan
- Reset with all valids=1: ptr=0, so EXU is granted first. Continuous valids then grant EXU, LSU, MDU, EXU, ...; no requester waits more than 2 cycles.
- Issue rd=5, then issue rs1=5 with the LSU not yet written back: iss_stall=1. In the cycle the LSU writes rd=5 (data 0xDEAD), iss_stall=0, and busy[5] is clear on the next cycle.
- Issue with rd=0 or rs1=0: never stalls, busy stays 0, and an EXU write to rd=0 gives exu_ready=1 with rf_wen=0.
- In the same cycle, MDU writes back x7 and the issue stage issues a new rd=7: busy[7]=1 afterwards (set wins).
- WAW: busy[3]=1 and an issue arrives with iss_rd=3, iss_wen=1: stall until the writeback to 3, then issue.
- Assert rst mid-stream with busy=0x0000_00F0 and ptr=2: busy=0 and ptr=0 without waiting for a clock edge, and the first grant after release goes to EXU.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
// Writeback/issue bundle between the execution units, decode and the
// register-file write-port scheduler.
interface regfile_wb_sched_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NREG       = 32
);
  // writeback requesters
  logic                  exu_valid, lsu_valid, mdu_valid;
  logic [4:0]            exu_rd, lsu_rd, mdu_rd;
  logic [DATA_WIDTH-1:0] exu_data, lsu_data, mdu_data;
  logic                  exu_ready, lsu_ready, mdu_ready;
  // register file write port
  logic                  rf_wen;
  logic [4:0]            rf_rd;
  logic [DATA_WIDTH-1:0] rf_wdata;
  // issue stage
  logic                  iss_valid, iss_wen;
  logic [4:0]            iss_rd, iss_rs1, iss_rs2;
  logic                  iss_use_rs1, iss_use_rs2;
  logic                  iss_stall;
  logic [NREG-1:0]       busy;

  modport master (
    output exu_valid, lsu_valid, mdu_valid, exu_rd, lsu_rd, mdu_rd,
           exu_data, lsu_data, mdu_data,
           iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2,
    input  exu_ready, lsu_ready, mdu_ready, rf_wen, rf_rd, rf_wdata, iss_stall, busy
  );

  modport slave (
    input  exu_valid, lsu_valid, mdu_valid, exu_rd, lsu_rd, mdu_rd,
           exu_data, lsu_data, mdu_data,
           iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2, iss_use_rs1, iss_use_rs2,
    output exu_ready, lsu_ready, mdu_ready, rf_wen, rf_rd, rf_wdata, iss_stall, busy
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: round-robin grant among EXU/LSU/MDU
// writebacks plus an in-flight destination scoreboard that stalls issue
// on RAW/WAW hazards. Same-cycle writeback data is forwarded by the RF,
// so a register being written this cycle never causes a stall.
module regfile_wb_sched #(
  parameter int DATA_WIDTH = 64,
  parameter int NREG       = 32
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_sched_if.slave bus
);
  localparam int NREQ = 3;  // 0=EXU, 1=LSU, 2=MDU

  logic [NREQ-1:0]                 req_v;
  logic [NREQ-1:0][4:0]            req_rd;
  logic [NREQ-1:0][DATA_WIDTH-1:0] req_data;

  assign req_v    = {bus.mdu_valid, bus.lsu_valid, bus.exu_valid};
  assign req_rd   = {bus.mdu_rd,    bus.lsu_rd,    bus.exu_rd};
  assign req_data = {bus.mdu_data,  bus.lsu_data,  bus.exu_data};

  logic [1:0]            ptr_q, ptr_d, ptr_eff;
  logic                  gnt_vld;
  logic [1:0]            gnt_idx;
  logic [NREQ-1:0]       gnt;
  logic                  wb_wen;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  logic [NREG-1:0]       busy_q, busy_d;
  logic                  raw1, raw2, waw, stall, iss_set;

  // Arbiter state: pointer and scoreboard, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= 2'd0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
    end
  end

  // Round-robin search starting at ptr; encoding 3 behaves like EXU first
  always_comb begin
    logic [2:0] slot;
    slot    = '0;
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    gnt     = '0;
    ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      slot = {1'b0, ptr_eff} + 3'(k);
      if (slot >= 3'd3) slot = slot - 3'd3;
      if (!gnt_vld && req_v[slot[1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = slot[1:0];
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  // Pointer advances past the granted slot; holds when nothing transfers
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
  end

  // Write-port mux; rd=0 still transfers but never enables the RF write
  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    if (gnt_vld) begin
      wb_rd   = req_rd[gnt_idx];
      wb_data = req_data[gnt_idx];
    end
    wb_wen = gnt_vld && (wb_rd != 5'd0);
  end

  // Hazard detection against the scoreboard, masked by same-cycle writeback
  always_comb begin
    raw1  = bus.iss_use_rs1 && (bus.iss_rs1 != 5'd0) && busy_q[bus.iss_rs1] &&
            !(wb_wen && wb_rd == bus.iss_rs1);
    raw2  = bus.iss_use_rs2 && (bus.iss_rs2 != 5'd0) && busy_q[bus.iss_rs2] &&
            !(wb_wen && wb_rd == bus.iss_rs2);
    waw   = bus.iss_wen && (bus.iss_rd != 5'd0) && busy_q[bus.iss_rd] &&
            !(wb_wen && wb_rd == bus.iss_rd);
    stall = bus.iss_valid && (raw1 || raw2 || waw);
    iss_set = bus.iss_valid && !stall && bus.iss_wen && (bus.iss_rd != 5'd0);
  end

  // Scoreboard update: clear on writeback, then set on issue (set wins)
  always_comb begin
    busy_d = busy_q;
    if (wb_wen)  busy_d[wb_rd]      = 1'b0;
    if (iss_set) busy_d[bus.iss_rd] = 1'b1;
  end

  assign bus.exu_ready = gnt[0];
  assign bus.lsu_ready = gnt[1];
  assign bus.mdu_ready = gnt[2];
  assign bus.rf_wen    = wb_wen;
  assign bus.rf_rd     = wb_rd;
  assign bus.rf_wdata  = wb_data;
  assign bus.iss_stall = stall;
  assign bus.busy      = busy_q;

  // A writeback must retire a register that is actually in flight
  wb_target_busy: assert property (@(posedge clk) disable iff (rst)
                                   wb_wen |-> busy_q[wb_rd]);
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: expected writebacks are queued as
// stimulus is driven and popped when the write port is sampled.
module tb_regfile_wb_sched;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_wb_sched_if #(.DATA_WIDTH(64), .NREG(32)) bus ();

  regfile_wb_sched #(.DATA_WIDTH(64), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [2:0]  rdy;   // {mdu,lsu,exu}
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] rdy, input logic wen, input logic [4:0] rd,
                      input logic [63:0] data);
    wb_exp_t e;
    e.rdy = rdy; e.wen = wen; e.rd = rd; e.data = data;
    exp_q.push_back(e);
  endtask

  // Compare the write port against the next queued expectation (idle if none)
  task automatic chk_wb(input string tag);
    wb_exp_t e;
    logic [2:0] rdy;
    e = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    rdy = {bus.mdu_ready, bus.lsu_ready, bus.exu_ready};
    chk({tag, ".rdy"},   64'(rdy),          64'(e.rdy));
    chk({tag, ".wen"},   64'(bus.rf_wen),   64'(e.wen));
    chk({tag, ".rd"},    64'(bus.rf_rd),    64'(e.rd));
    chk({tag, ".wdata"}, bus.rf_wdata,      e.data);
  endtask

  task automatic wb(input int who, input logic v, input logic [4:0] rd, input logic [63:0] d);
    case (who)
      0: begin bus.exu_valid = v; bus.exu_rd = rd; bus.exu_data = d; end
      1: begin bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_data = d; end
      default: begin bus.mdu_valid = v; bus.mdu_rd = rd; bus.mdu_data = d; end
    endcase
  endtask

  task automatic iss(input logic v, input logic wen, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2);
    bus.iss_valid = v; bus.iss_wen = wen; bus.iss_rd = rd;
    bus.iss_rs1 = rs1; bus.iss_use_rs1 = u1;
    bus.iss_rs2 = rs2; bus.iss_use_rs2 = u2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] rr_tbl [6];
    rr_tbl = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    rst = 1'b1;
    wb(0, 0, 0, 0); wb(1, 0, 0, 0); wb(2, 0, 0, 0);
    iss(0, 0, 0, 0, 0, 0, 0);

    // reset state
    @(negedge clk);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.stall", 64'(bus.iss_stall), 64'd0);
    chk_wb("rst.idle");

    // all requesters valid (rd=0): EXU first, then strict rotation
    wb(0, 1, 0, 64'd1); wb(1, 1, 0, 64'd2); wb(2, 1, 0, 64'd3);
    #1;
    push(3'b001, 0, 0, 64'd1);
    chk_wb("rst.grant");
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) push(rr_tbl[i], 0, 0, 64'(rr_tbl[i] == 3'b001 ? 1 :
                                                          rr_tbl[i] == 3'b010 ? 2 : 3));
    for (int i = 0; i < 6; i++) begin
      chk_wb("rr");
      @(posedge clk);
      @(negedge clk);
    end
    wb(0, 0, 0, 0); wb(1, 0, 0, 0); wb(2, 0, 0, 0);
    tick();

    // RAW on rs1 until LSU writes back x5 (forwarded in that cycle)
    iss(1, 1, 5, 0, 0, 0, 0);
    @(negedge clk);
    chk("raw.issue_rd", 64'(bus.iss_stall), 64'd0);
    tick();
    iss(1, 0, 0, 5, 1, 0, 0);
    @(negedge clk);
    chk("raw.busy", 64'(bus.busy), 64'h20);
    chk("raw.stall", 64'(bus.iss_stall), 64'd1);
    tick();
    @(negedge clk);
    chk("raw.hold", 64'(bus.iss_stall), 64'd1);
    tick();
    wb(1, 1, 5, 64'hDEAD);
    push(3'b010, 1, 5, 64'hDEAD);
    @(negedge clk);
    chk("raw.fwd", 64'(bus.iss_stall), 64'd0);
    chk_wb("raw.wb");
    tick();
    wb(1, 0, 0, 0);
    iss(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("raw.clear", 64'(bus.busy), 64'd0);

    // x0 never tracked; EXU write to x0 is accepted without RF write
    iss(1, 1, 0, 0, 1, 0, 1);
    wb(0, 1, 0, 64'h55);
    push(3'b001, 0, 0, 64'h55);
    #1;
    chk("x0.stall", 64'(bus.iss_stall), 64'd0);
    chk_wb("x0.wb");
    tick();
    wb(0, 0, 0, 0);
    iss(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("x0.busy", 64'(bus.busy), 64'd0);

    // same-cycle MDU writeback and re-issue of x7: set wins
    iss(1, 1, 7, 0, 0, 0, 0);
    tick();
    wb(2, 1, 7, 64'h77);
    push(3'b100, 1, 7, 64'h77);
    @(negedge clk);
    chk("setwin.busy0", 64'(bus.busy), 64'h80);
    chk("setwin.stall", 64'(bus.iss_stall), 64'd0);
    chk_wb("setwin.wb");
    tick();
    wb(2, 0, 0, 0);
    iss(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("setwin.busy1", 64'(bus.busy), 64'h80);
    wb(2, 1, 7, 64'h78);
    push(3'b100, 1, 7, 64'h78);
    #1 chk_wb("setwin.drain");
    tick();
    wb(2, 0, 0, 0);
    @(negedge clk);
    chk("setwin.busy2", 64'(bus.busy), 64'd0);

    // WAW on x3: stall until EXU writes x3 back
    iss(1, 1, 3, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    chk("waw.busy", 64'(bus.busy), 64'h8);
    chk("waw.stall", 64'(bus.iss_stall), 64'd1);
    tick();
    @(negedge clk);
    chk("waw.hold", 64'(bus.iss_stall), 64'd1);
    wb(0, 1, 3, 64'h33);
    push(3'b001, 1, 3, 64'h33);
    #1;
    chk("waw.release", 64'(bus.iss_stall), 64'd0);
    chk_wb("waw.wb");
    tick();
    wb(0, 0, 0, 0);
    iss(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("waw.reissued", 64'(bus.busy), 64'h8);
    wb(0, 1, 3, 64'h34);
    push(3'b001, 1, 3, 64'h34);
    #1 chk_wb("waw.drain");
    tick();
    wb(0, 0, 0, 0);
    @(negedge clk);
    chk("waw.busy_end", 64'(bus.busy), 64'd0);

    // mid-stream async reset with busy=0xF0, ptr=2
    for (int r = 4; r < 8; r++) begin
      iss(1, 1, 5'(r), 0, 0, 0, 0);
      tick();
    end
    iss(0, 0, 0, 0, 0, 0, 0);
    wb(1, 1, 0, 64'h9);
    push(3'b010, 0, 0, 64'h9);
    #1 chk_wb("pre.lsu");
    tick();
    wb(1, 0, 0, 0);
    @(negedge clk);
    chk("pre.busy", 64'(bus.busy), 64'hF0);
    wb(0, 1, 0, 64'd1); wb(1, 1, 0, 64'd2); wb(2, 1, 0, 64'd3);
    push(3'b100, 0, 0, 64'd3);
    #1 chk_wb("pre.ptr2");
    #1 rst = 1'b1;
    #1;
    chk("arst.busy", 64'(bus.busy), 64'd0);
    push(3'b001, 0, 0, 64'd1);
    chk_wb("arst.ptr0");
    #1 rst = 1'b0;
    push(3'b001, 0, 0, 64'd1);
    chk_wb("post.first");
    @(negedge clk);
    wb(0, 0, 0, 0); wb(1, 0, 0, 0); wb(2, 0, 0, 0);
    #1;
    chk("post.qempty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
